// File: rtl/rbus_conf_master.sv
// Initiator side of the RBUS configuration handshake; after configuration it
// streams an image and drives the per-line SetEn/OEn/Wptclr/Rptclr vectors.
module rbus_conf_master #(
    parameter int NUM_LINES           = 13,
    parameter int BITWIDTH_W_COLUMS   = 4,
    parameter int BITWIDTH_MAX_W_SIZE = 9,
    parameter int BITWIDTH_IMG        = 10,
    parameter int TIMEOUT             = 64
) (
    input  logic                           RBUS_CONF_Clk,
    input  logic                           RBUS_CONF_Reset,
    input  logic                           RBUS_CONF_Start,
    input  logic [BITWIDTH_W_COLUMS-1:0]   RBUS_CONF_W_Colums_In,
    input  logic [BITWIDTH_MAX_W_SIZE-1:0] RBUS_CONF_W_ROXCL_In,
    input  logic [BITWIDTH_IMG-1:0]        RBUS_CONF_Img_Width,
    input  logic [BITWIDTH_IMG-1:0]        RBUS_CONF_Img_Height,
    input  logic                           RBUS_CONF_Pixel_Valid,
    input  logic                           RBUS_CONF_Set_Conf_Already,
    output logic                           RBUS_CONF_Set_Conf,
    output logic                           RBUS_CONF_Set_Conf_Already_Ok,
    output logic [BITWIDTH_W_COLUMS-1:0]   RBUS_CONF_W_Colums,
    output logic [BITWIDTH_MAX_W_SIZE-1:0] RBUS_CONF_W_ROXCL,
    output logic [NUM_LINES-1:0]           RBUS_CONF_SetEn,
    output logic [NUM_LINES-1:0]           RBUS_CONF_OEn,
    output logic [NUM_LINES-1:0]           RBUS_CONF_Wptclr,
    output logic [NUM_LINES-1:0]           RBUS_CONF_Rptclr,
    output logic                           RBUS_CONF_Busy,
    output logic                           RBUS_CONF_Done,
    output logic                           RBUS_CONF_Err
);

    localparam int KW  = BITWIDTH_W_COLUMS;
    localparam int IW  = BITWIDTH_IMG;
    localparam int TOW = $clog2(TIMEOUT) + 1;
    localparam logic [KW-1:0]  K_ONE    = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]  IMG_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [TOW-1:0] TO_ONE   = {{(TOW-1){1'b0}}, 1'b1};
    localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONF_REQ = 3'd1,
        S_CONF_ACK = 3'd2,
        S_CLEAR    = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t r_state, w_state_nxt;

    logic [KW-1:0]                  r_k, r_wr_idx, r_filled, w_wr_idx_nxt, w_filled_nxt, w_k_m1;
    logic [BITWIDTH_MAX_W_SIZE-1:0] r_w_roxcl;
    logic [IW-1:0]                  r_img_w, r_img_h, r_col, r_row, w_col_nxt, w_row_nxt;
    logic [TOW-1:0]                 r_tmo, w_tmo_nxt;
    logic                           w_latch, w_k_ok;
    logic [NUM_LINES-1:0]           w_mask, w_mask_in;
    logic [NUM_LINES-1:0]           w_seten_nxt, w_oen_nxt, w_wptclr_nxt, w_rptclr_nxt;
    logic                           w_err_nxt;

    logic                           r_set_conf, r_ok, r_busy, r_done, r_err;
    logic [NUM_LINES-1:0]           r_seten, r_oen, r_wptclr, r_rptclr;

    function automatic logic [NUM_LINES-1:0] f_mask(input logic [KW-1:0] k);
        logic [NUM_LINES-1:0] m;
        m = {NUM_LINES{1'b0}};
        for (int i = 0; i < NUM_LINES; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    function automatic logic [NUM_LINES-1:0] f_onehot(input logic [KW-1:0] idx);
        logic [NUM_LINES-1:0] m;
        m = {NUM_LINES{1'b0}};
        for (int i = 0; i < NUM_LINES; i++) begin
            m[i] = (i == int'(idx));
        end
        return m;
    endfunction

    assign w_k_ok    = (RBUS_CONF_W_Colums_In != {KW{1'b0}}) &&
                       (int'(RBUS_CONF_W_Colums_In) <= NUM_LINES);
    assign w_k_m1    = r_k - K_ONE;
    assign w_mask    = f_mask(r_k);
    assign w_mask_in = f_mask(RBUS_CONF_W_Colums_In);

    // Next-state, counter and line-vector decode; outputs are registered from these.
    always_comb begin
        w_state_nxt  = r_state;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_wr_idx_nxt = r_wr_idx;
        w_filled_nxt = r_filled;
        w_tmo_nxt    = r_tmo;
        w_latch      = 1'b0;
        w_err_nxt    = 1'b0;
        w_seten_nxt  = {NUM_LINES{1'b0}};
        w_oen_nxt    = {NUM_LINES{1'b0}};
        w_wptclr_nxt = {NUM_LINES{1'b0}};
        w_rptclr_nxt = {NUM_LINES{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (RBUS_CONF_Start && w_k_ok) begin
                    w_latch     = 1'b1;
                    w_tmo_nxt   = {TOW{1'b0}};
                    w_state_nxt = S_CONF_REQ;
                end else if (RBUS_CONF_Start) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONF_REQ: begin
                if (RBUS_CONF_Set_Conf_Already) begin
                    w_state_nxt = S_CONF_ACK;
                end else if (r_tmo == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TO_ONE;
                end
            end
            S_CONF_ACK: begin
                w_state_nxt  = S_CLEAR;
                w_wptclr_nxt = w_mask;
                w_rptclr_nxt = w_mask;
            end
            S_CLEAR: begin
                w_state_nxt  = S_RUN;
                w_col_nxt    = {IW{1'b0}};
                w_row_nxt    = {IW{1'b0}};
                w_wr_idx_nxt = {KW{1'b0}};
                w_filled_nxt = {KW{1'b0}};
            end
            S_RUN: begin
                if (RBUS_CONF_Pixel_Valid) begin
                    w_seten_nxt = f_onehot(r_wr_idx);
                    w_oen_nxt   = (r_filled == w_k_m1) ? w_mask : {NUM_LINES{1'b0}};
                    if (r_col == r_img_w && r_row == r_img_h) begin
                        w_state_nxt = S_DONE;
                    end else if (r_col == r_img_w) begin
                        // Row end: advance to the next line buffer and clear its pointers.
                        w_col_nxt    = {IW{1'b0}};
                        w_row_nxt    = r_row + IMG_ONE;
                        w_wr_idx_nxt = (r_wr_idx == w_k_m1) ? {KW{1'b0}} : r_wr_idx + K_ONE;
                        w_filled_nxt = (r_filled == w_k_m1) ? r_filled : r_filled + K_ONE;
                        w_wptclr_nxt = f_onehot(w_wr_idx_nxt);
                        w_rptclr_nxt = w_mask;
                    end else begin
                        w_col_nxt = r_col + IMG_ONE;
                    end
                end else begin
                    w_seten_nxt = {NUM_LINES{1'b0}};
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge RBUS_CONF_Clk or posedge RBUS_CONF_Reset) begin
        if (RBUS_CONF_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, latched configuration and registered outputs.
    always_ff @(posedge RBUS_CONF_Clk or posedge RBUS_CONF_Reset) begin
        if (RBUS_CONF_Reset) begin
            r_k        <= {KW{1'b0}};
            r_w_roxcl  <= {BITWIDTH_MAX_W_SIZE{1'b0}};
            r_img_w    <= {IW{1'b0}};
            r_img_h    <= {IW{1'b0}};
            r_col      <= {IW{1'b0}};
            r_row      <= {IW{1'b0}};
            r_wr_idx   <= {KW{1'b0}};
            r_filled   <= {KW{1'b0}};
            r_tmo      <= {TOW{1'b0}};
            r_set_conf <= 1'b0;
            r_ok       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_seten    <= {NUM_LINES{1'b0}};
            r_oen      <= {NUM_LINES{1'b0}};
            r_wptclr   <= {NUM_LINES{1'b0}};
            r_rptclr   <= {NUM_LINES{1'b0}};
        end else begin
            if (w_latch) begin
                r_k       <= RBUS_CONF_W_Colums_In;
                r_w_roxcl <= RBUS_CONF_W_ROXCL_In;
                r_img_w   <= RBUS_CONF_Img_Width;
                r_img_h   <= RBUS_CONF_Img_Height;
            end
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_wr_idx   <= w_wr_idx_nxt;
            r_filled   <= w_filled_nxt;
            r_tmo      <= w_tmo_nxt;
            r_set_conf <= (w_state_nxt == S_CONF_REQ);
            r_ok       <= (w_state_nxt == S_CONF_ACK);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= w_err_nxt;
            r_seten    <= w_seten_nxt;
            r_oen      <= w_oen_nxt;
            r_wptclr   <= w_wptclr_nxt;
            r_rptclr   <= w_rptclr_nxt;
        end
    end

    // The input-side mask is kept for symmetry with the latched one but only r_k drives outputs.
    logic w_unused;
    assign w_unused = ^w_mask_in;

    assign RBUS_CONF_Set_Conf            = r_set_conf;
    assign RBUS_CONF_Set_Conf_Already_Ok = r_ok;
    assign RBUS_CONF_W_Colums            = r_k;
    assign RBUS_CONF_W_ROXCL             = r_w_roxcl;
    assign RBUS_CONF_SetEn               = r_seten;
    assign RBUS_CONF_OEn                 = r_oen;
    assign RBUS_CONF_Wptclr              = r_wptclr;
    assign RBUS_CONF_Rptclr              = r_rptclr;
    assign RBUS_CONF_Busy                = r_busy;
    assign RBUS_CONF_Done                = r_done;
    assign RBUS_CONF_Err                 = r_err;

endmodule
